// File: rtl/cache_pkg.sv
// Shared cache types and widths used by L1_D and its miss responder.
package cache_pkg;

   localparam int LINE_W  = 128;
   localparam int ADDR_W  = 64;
   localparam int WDATA_W = 64;
   localparam int BOFF_W  = 4;    // byte offset within a 16-byte line

   // Access size encodings; 4-7 are illegal.
   typedef enum logic [2:0] {
      SZ_B = 3'd0,
      SZ_H = 3'd1,
      SZ_W = 3'd2,
      SZ_D = 3'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } resp_state_e;

   // Number of bytes touched by a legal size code (1, 2, 4 or 8).
   function automatic logic [BOFF_W:0] size_bytes(input logic [1:0] sz);
      return (BOFF_W+1)'(1) << sz;
   endfunction

endpackage

// File: rtl/line_merge.sv
// Merges a right-aligned write of 1/2/4/8 bytes into a 128-bit line.
// Flags illegal size codes and misaligned offsets; an illegal write
// leaves the line untouched.
module line_merge
   import cache_pkg::*;
(
   input  logic [LINE_W-1:0]  line,
   input  logic [WDATA_W-1:0] data,
   input  logic [2:0]         size,
   input  logic [BOFF_W-1:0]  offset,
   output logic [LINE_W-1:0]  merged,
   output logic               illegal
);

   logic [BOFF_W:0] nbytes;
   logic            size_ok;
   logic            align_ok;

   assign size_ok  = (size <= 3'(SZ_D));
   assign nbytes   = size_bytes(size[1:0]);
   // Aligned means the offset is a multiple of the access size; since the
   // size is at most 8, an aligned access never crosses the line end.
   assign align_ok = ((offset & (nbytes[BOFF_W-1:0] - 4'd1)) == '0);
   assign illegal  = !(size_ok && align_ok);

   // One lane per line byte: take data byte (gi - offset) when inside the window.
   generate
      for (genvar gi = 0; gi < LINE_W/8; gi++) begin : g_byte
         logic [BOFF_W-1:0] rel;
         logic              hit;
         assign rel = BOFF_W'(gi) - offset;
         assign hit = !illegal && (BOFF_W'(gi) >= offset) && ({1'b0, rel} < nbytes);
         assign merged[gi*8 +: 8] = hit ? data[{rel[2:0], 3'b000} +: 8] : line[gi*8 +: 8];
      end
   endgenerate

endmodule

// File: rtl/l1_miss_responder.sv
// Backing-store model behind L1_D: accepts forwarded read, write and
// line-flush requests over a four-phase req/done handshake and returns
// the addressed 128-bit line after a programmable latency.
module l1_miss_responder
   import cache_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int IDX_W   = 6,
   parameter int LATENCY = 4
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req,
   input  logic               write_enable_in,
   input  logic [WDATA_W-1:0] write_data_in,
   input  logic [ADDR_W-1:0]  address_in,
   input  logic [2:0]         write_size_in,
   input  logic               CLF_in,
   output logic [LINE_W-1:0]  data_out,
   output logic               done,
   output logic               err,
   output logic [31:0]        req_count
);

   resp_state_e               state_reg, state_next;
   logic [7:0]                cnt_reg;
   logic [IDX_W+BOFF_W-1:0]   addr_reg;
   logic [2:0]                size_reg;
   logic [WDATA_W-1:0]        wdata_reg;
   logic                      we_reg;
   logic                      clf_reg;
   logic [LINE_W-1:0]         data_reg;
   logic                      err_reg;
   logic [31:0]               count_reg;
   logic [LINE_W-1:0]         mem [DEPTH];

   logic [IDX_W-1:0]          idx;
   logic [BOFF_W-1:0]         off;
   logic [LINE_W-1:0]         cur_line;
   logic [LINE_W-1:0]         merged_line;
   logic                      illegal;
   logic                      accept;
   logic                      finish;
   logic                      write_hit;
   logic                      unused_addr_bits;

   // Upper address bits alias onto the same lines by design.
   assign unused_addr_bits = ^address_in[ADDR_W-1:IDX_W+BOFF_W];

   assign idx       = addr_reg[IDX_W+BOFF_W-1:BOFF_W];
   assign off       = addr_reg[BOFF_W-1:0];
   assign cur_line  = mem[idx];
   assign accept    = (state_reg == IDLE) && req;
   assign finish    = (state_reg == BUSY) && (cnt_reg == 8'd0);
   // Flush wins over write; illegal writes never touch storage.
   assign write_hit = finish && !clf_reg && we_reg && !illegal;

   line_merge u_merge (
      .line    (cur_line),
      .data    (wdata_reg),
      .size    (size_reg),
      .offset  (off),
      .merged  (merged_line),
      .illegal (illegal)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic for the req/done handshake.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (req)    state_next = BUSY;
         BUSY:    if (finish) state_next = DONE;
         DONE:    if (!req)   state_next = IDLE;
         default:             state_next = IDLE;
      endcase
   end

   // Request latch, latency counter, response data and request counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg   <= '0;
         addr_reg  <= '0;
         size_reg  <= '0;
         wdata_reg <= '0;
         we_reg    <= 1'b0;
         clf_reg   <= 1'b0;
         data_reg  <= '0;
         err_reg   <= 1'b0;
         count_reg <= '0;
      end else begin
         if (accept) begin
            addr_reg  <= address_in[IDX_W+BOFF_W-1:0];
            size_reg  <= write_size_in;
            wdata_reg <= write_data_in;
            we_reg    <= write_enable_in;
            clf_reg   <= CLF_in;
            cnt_reg   <= 8'(LATENCY - 1);
            count_reg <= count_reg + 32'd1;
         end else if (state_reg == BUSY && cnt_reg != 8'd0) begin
            cnt_reg <= cnt_reg - 8'd1;
         end
         if (finish) begin
            if (clf_reg || !we_reg) begin
               data_reg <= cur_line;
               err_reg  <= 1'b0;
            end else if (illegal) begin
               data_reg <= cur_line;
               err_reg  <= 1'b1;
            end else begin
               data_reg <= merged_line;
               err_reg  <= 1'b0;
            end
         end
      end
   end

   // Line storage; cleared on reset, written only by a legal write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (write_hit) begin
         mem[idx] <= merged_line;
      end
   end

   assign data_out  = data_reg;
   assign err       = err_reg;
   assign done      = (state_reg == DONE);
   assign req_count = count_reg;

endmodule
